stone_renderer: RTL and testbench
=================================

// Module: stone_renderer
// PURPOSE
//  Per-frame drawing stage for the stone/gold/diamond table shared with the rope controller.
//  On each frame tick it walks entries 0..quantity-1 of the item RAM and plots every visible item as a 16x16 square.
//  While it walks, it holds draw_stone_flag high so the rope controller pauses and the RAM address mux selects draw_index.
//  Output is a single-pixel plot stream for the 320x240 VGA adapter.
// PARAMETERS
//  RAM_LAT     2       cycles from draw_index change to valid ram_q
//  SPRITE      16      square edge in pixels (power of 2)
//  SCREEN_W    320     pixels with x >= SCREEN_W are never plotted
//  SCREEN_H    240     pixels with y >= SCREEN_H are never plotted
//  BG_COLOUR   3'b000  background colour, used only by the erase pass
// PORTS
//  clock            in   1   system clock
//  resetn           in   1   synchronous, active-low reset
//  start            in   1   frame tick pulse; ignored while busy
//  quantity         in   4   number of valid RAM entries, 0..15
//  ram_q            in   32  item record: [31:23]=x, [18:11]=y, [3:2]=type, [1]=visible, [0]=moving
//  draw_stone_flag  out  1   high for the whole pass; this block owns the RAM address while high
//  draw_index       out  4   RAM address
//  vga_x            out  9   pixel x
//  vga_y            out  8   pixel y
//  vga_colour       out  3   pixel RGB
//  plot             out  1   pixel write strobe
//  done             out  1   one-cycle pulse at the end of each pass
// BEHAVIOUR
//  Reset value of all outputs is 0; state returns to IDLE. A reset in mid-pass aborts immediately; plot and flag are low on the next cycle.
//  States: IDLE -> WAIT -> LATCH -> [ERASE] -> DRAW -> NEXT -> DONE -> IDLE.
//  IDLE: on start with quantity==0, go to DONE. On start otherwise: draw_index<=0, draw_stone_flag<=1, go to WAIT.
//  WAIT: hold draw_index for exactly RAM_LAT cycles.
//  LATCH: capture ram_q.
//    visible=1: go to DRAW.
//    visible=0: go to NEXT (or ERASE, see CONFIGURATION).
//  DRAW: scan 256 cycles, row-major, 8-bit counter {dy,dx}.
//    Each cycle: vga_x=x+dx, vga_y=y+dy, plot=1.
//    If a pixel is off screen, plot=0 but the counter still advances.
//    Compute coordinates at 10/9 bits so there is no wrap-around.
//  Colour by type: 0 stone 3'b111, 1 gold 3'b110, 2 diamond 3'b011, 3 3'b101. The moving bit does not change the colour.
//  NEXT: if draw_index==quantity-1, go to DONE. Otherwise draw_index++ and go to WAIT.
//  DONE: done=1 for 1 cycle, flag stays high this cycle, then IDLE with flag=0.
//  Cycles per entry: RAM_LAT+2 if invisible, RAM_LAT+258 if visible.
//  The first plot is asserted RAM_LAT+2 cycles after start is sampled.
//  quantity is sampled only at start. If quantity changes mid-pass, the current pass is unaffected.
//  start arriving in the same cycle as done is ignored; the pass is not retriggered.
// CONFIGURATION
//  STONE_ERASE_EN defined:
//    Adds 16 shadow registers {x,y,valid}, cleared by reset.
//    After LATCH, if shadow valid and (x/y differs or visible==0): ERASE paints the shadow square in BG_COLOUR (256 cycles, same clipping), then continues to DRAW or NEXT.
//    On DRAW, the shadow is set to the new x,y with valid=1. On invisible, valid=0.
//  STONE_ERASE_EN not defined: no shadow registers and no ERASE state. Stale squares are the frame-clear logic's concern.
// STRUCTURE
//  Package gm_pkg holds:
//    record field positions (X_MSB/LSB, Y_MSB/LSB, TYPE, VIS, MOV)
//    type codes and colour constants
//    SCREEN_W/H
//    the state enum
//  Sub-module sprite_scan: 8-bit dx/dy counter with start, last, clip, and x/y output. Shared by DRAW and ERASE.
// TESTING
//  1. quantity=0, start -> done 1 cycle later, no plot, flag high only for the DONE cycle.
//  2. quantity=1, entry0 x=100 y=50 type=1 vis=1, RAM_LAT=2 -> first plot (100,50,3'b110) 4 cycles after start; last (115,65); 256 plots; done next-next cycle.
//  3. quantity=3, entry1 invisible -> draw_index sequence 0,1,2; exactly 512 plots; pass length 2*260+4 cycles plus DONE.
//  4. Entry x=310 y=230 -> only the 10x10 on-screen pixels are plotted (100 plots); counter still runs 256 cycles.
//  5. Pulse start mid-pass, then resetn=0 mid-DRAW -> start ignored; after reset, plot, flag, done and draw_index are all 0.
//  6. STONE_ERASE_EN: pass with x=100, then with x=120 -> second pass emits 256 BG_COLOUR plots at (100..115) before the new square.

Source files
------------

// File: rtl/gm_pkg.sv
// Shared definitions for the stone/gold/diamond drawing stage.
// Optional feature macro: STONE_ERASE_EN (adds the ERASE state).
package gm_pkg;

  // Item record field positions.
  localparam int unsigned X_MSB    = 31;
  localparam int unsigned X_LSB    = 23;
  localparam int unsigned Y_MSB    = 18;
  localparam int unsigned Y_LSB    = 11;
  localparam int unsigned TYPE_MSB = 3;
  localparam int unsigned TYPE_LSB = 2;
  localparam int unsigned VIS      = 1;
  localparam int unsigned MOV      = 0;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef enum logic [1:0] {
    T_STONE   = 2'd0,
    T_GOLD    = 2'd1,
    T_DIAMOND = 2'd2,
    T_OTHER   = 2'd3
  } item_t;

  localparam logic [2:0] C_STONE   = 3'b111;
  localparam logic [2:0] C_GOLD    = 3'b110;
  localparam logic [2:0] C_DIAMOND = 3'b011;
  localparam logic [2:0] C_OTHER   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LATCH,
`ifdef STONE_ERASE_EN
    S_ERASE,
`endif
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic [2:0] colour_of(input logic [1:0] t);
    case (item_t'(t))
      T_STONE:   return C_STONE;
      T_GOLD:    return C_GOLD;
      T_DIAMOND: return C_DIAMOND;
      default:   return C_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/stone_renderer_if.sv
// Single-pixel plot stream towards the 320x240 VGA adapter.
interface stone_renderer_if;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  modport master (output vga_x, vga_y, vga_colour, plot);
  modport slave  (input  vga_x, vga_y, vga_colour, plot);
endinterface

// File: rtl/sprite_scan.sv
// Row-major {dy,dx} scan over one SPRITE x SPRITE square with screen clipping.
module sprite_scan #(
  parameter int unsigned SPRITE   = 16,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       en,
  input  logic [8:0] base_x,
  input  logic [7:0] base_y,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       on_screen,
  output logic       last
);
  localparam int unsigned SB = $clog2(SPRITE);
  localparam int unsigned CW = 2 * SB;

  logic [CW-1:0] cnt;
  logic [SB-1:0] dx, dy;
  logic [9:0]    px;
  logic [8:0]    py;

  // Counter is held at zero outside a scan and wraps naturally after the last pixel.
  always_ff @(posedge clock) begin
    if (!resetn || start) cnt <= '0;
    else if (en)          cnt <= cnt + CW'(1);
  end

  // Coordinates are formed one bit wider so squares near the edge never wrap back on screen.
  always_comb begin
    dx        = cnt[SB-1:0];
    dy        = cnt[CW-1:SB];
    px        = {1'b0, base_x} + 10'(dx);
    py        = {1'b0, base_y} + 9'(dy);
    on_screen = (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
    last      = &cnt;
    x         = px[8:0];
    y         = py[7:0];
  end
endmodule

// File: rtl/stone_renderer.sv
// Per-frame item drawing stage: walks the item RAM and plots each visible item as a square.
// Optional feature macro: STONE_ERASE_EN (shadow registers + ERASE pass of the old square).
module stone_renderer #(
  parameter int unsigned RAM_LAT   = 2,
  parameter int unsigned SPRITE    = 16,
  parameter int unsigned SCREEN_W  = gm_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H  = gm_pkg::SCREEN_H,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [3:0]        quantity,
  input  logic [31:0]       ram_q,
  output logic              draw_stone_flag,
  output logic [3:0]        draw_index,
  output logic              done,
  stone_renderer_if.master  pix
);
  import gm_pkg::*;

  localparam logic [3:0] WAIT_LAST = 4'(RAM_LAT - 1);

  state_t     state, nxt;
  logic [3:0] qty_r;
  logic [3:0] wait_cnt;
  logic [8:0] lat_x;
  logic [7:0] lat_y;
  logic [1:0] lat_type;
  logic       lat_vis;
  logic       scan_en, erase_sel;
  logic [8:0] base_x, scan_x;
  logic [7:0] base_y, scan_y;
  logic       scan_on, scan_last;
  logic       unused_rec_bits;

  // Record bits that play no part in drawing.
  always_comb unused_rec_bits = ^{ram_q[22:19], ram_q[10:4], ram_q[MOV]};

`ifdef STONE_ERASE_EN
  logic [8:0]  sh_x [16];
  logic [7:0]  sh_y [16];
  logic [15:0] sh_v;
  logic        need_erase;

  // The old square must go if it was drawn and the item has moved or vanished.
  always_comb need_erase = sh_v[draw_index] &&
                           ((sh_x[draw_index] != ram_q[X_MSB:X_LSB]) ||
                            (sh_y[draw_index] != ram_q[Y_MSB:Y_LSB]) || !ram_q[VIS]);

  // Shadow records what is on screen once each entry has been handled.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 16; i++) begin
        sh_x[4'(i)] <= '0;
        sh_y[4'(i)] <= '0;
      end
      sh_v <= '0;
    end else if (state == S_NEXT) begin
      sh_x[draw_index] <= lat_x;
      sh_y[draw_index] <= lat_y;
      sh_v[draw_index] <= lat_vis;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = (quantity == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) nxt = S_LATCH;
      S_LATCH: begin
        nxt = ram_q[VIS] ? S_DRAW : S_NEXT;
`ifdef STONE_ERASE_EN
        if (need_erase) nxt = S_ERASE;
`endif
      end
`ifdef STONE_ERASE_EN
      S_ERASE: if (scan_last) nxt = lat_vis ? S_DRAW : S_NEXT;
`endif
      S_DRAW:  if (scan_last) nxt = S_NEXT;
      S_NEXT:  nxt = (draw_index == qty_r - 4'd1) ? S_DONE : S_WAIT;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and scan counter.
  always_comb begin
    draw_stone_flag = (state != S_IDLE);
    done            = (state == S_DONE);
    scan_en         = (state == S_DRAW);
    erase_sel       = 1'b0;
`ifdef STONE_ERASE_EN
    if (state == S_ERASE) begin
      scan_en   = 1'b1;
      erase_sel = 1'b1;
    end
`endif
    pix.plot       = scan_en && scan_on;
    pix.vga_x      = scan_en ? scan_x : '0;
    pix.vga_y      = scan_en ? scan_y : '0;
    pix.vga_colour = !scan_en ? '0 : (erase_sel ? BG_COLOUR : colour_of(lat_type));
  end

  // RAM walk bookkeeping: index, sampled quantity, latency wait and record capture.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      draw_index <= '0;
      qty_r      <= '0;
      wait_cnt   <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_type   <= '0;
      lat_vis    <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : '0;
      if (state == S_IDLE && start) begin
        draw_index <= '0;
        qty_r      <= quantity;
      end
      if (state == S_NEXT && nxt == S_WAIT) draw_index <= draw_index + 4'd1;
      if (state == S_LATCH) begin
        lat_x    <= ram_q[X_MSB:X_LSB];
        lat_y    <= ram_q[Y_MSB:Y_LSB];
        lat_type <= ram_q[TYPE_MSB:TYPE_LSB];
        lat_vis  <= ram_q[VIS];
      end
    end
  end

  // Scan base: the erase pass repaints where the item was, the draw pass where it is now.
  always_comb begin
    base_x = lat_x;
    base_y = lat_y;
`ifdef STONE_ERASE_EN
    if (erase_sel) begin
      base_x = sh_x[draw_index];
      base_y = sh_y[draw_index];
    end
`endif
  end

  sprite_scan #(
    .SPRITE   (SPRITE),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clock     (clock),
    .resetn    (resetn),
    .start     (!scan_en),
    .en        (scan_en),
    .base_x    (base_x),
    .base_y    (base_y),
    .x         (scan_x),
    .y         (scan_y),
    .on_screen (scan_on),
    .last      (scan_last)
  );
endmodule

// File: tb/tb_stone_renderer.sv
// Self-checking bench for stone_renderer: table vectors, hand sequences and random passes
// compared against a pixel-list model built directly from the item records.
module tb_stone_renderer;
  localparam int BUDGET = 16 * 520 + 40;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  quantity = '0;
  logic [31:0] ram_q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic        done;

  stone_renderer_if pix();

  stone_renderer #(.RAM_LAT(2)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .quantity        (quantity),
    .ram_q           (ram_q),
    .draw_stone_flag (draw_stone_flag),
    .draw_index      (draw_index),
    .done            (done),
    .pix             (pix)
  );

  always #5 clock = ~clock;

  // Item RAM with two cycles from address to data.
  logic [31:0] mem [16];
  logic [31:0] q1;
  always @(posedge clock) begin
    q1    <= mem[draw_index];
    ram_q <= q1;
  end

  int vectors = 0;
  int miscompares = 0;
  int flag_cyc, first_lat, done_lat, exp_cyc;
  logic [19:0] got_q [$];
  logic [19:0] exp_q [$];
  logic [3:0]  idx_q [$];
  logic [2:0]  col_tab [4];

  typedef struct {
    int          qty;
    logic [31:0] e0, e1, e2;
    int          exp_plots;
    int          exp_cyc;
  } vec_t;
  vec_t tab [8];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rec(input int x, input int y, input int t, input int v, input int m);
    logic [31:0] r;
    r = $urandom;
    r[31:23] = 9'(x);
    r[18:11] = 8'(y);
    r[3:2]   = 2'(t);
    r[1]     = v[0];
    r[0]     = m[0];
    return r;
  endfunction

  // Expected pixel list and pass length straight from the drawing rules.
  function automatic void build_exp(input int qty);
    logic [31:0] r;
    int x, y;
    exp_q.delete();
    exp_cyc = 1;
    for (int i = 0; i < qty; i++) begin
      r = mem[i];
      x = int'(r[31:23]);
      y = int'(r[18:11]);
      if (r[1]) begin
        exp_cyc += 260;
        for (int dy = 0; dy < 16; dy++)
          for (int dx = 0; dx < 16; dx++)
            if (x + dx < 320 && y + dy < 240)
              exp_q.push_back({9'(x + dx), 8'(y + dy), col_tab[r[3:2]]});
      end else begin
        exp_cyc += 4;
      end
    end
  endfunction

  task automatic cmp_list(input string tag);
    int m;
    m = 0;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] != exp_q[k]) m++;
    check({tag, "_pixels"}, m, 0);
  endtask

  task automatic check_idx(input string tag, input int qty);
    int m;
    m = 0;
    check({tag, "_idxlen"}, idx_q.size(), qty);
    for (int k = 0; k < idx_q.size(); k++)
      if (idx_q[k] != 4'(k)) m++;
    check({tag, "_idxseq"}, m, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // One pass: n counts cycles after the edge that samples start; quantity is scrambled mid-pass.
  task automatic run_pass(input int mid_at, input bit retrig);
    int n;
    bit seen;
    got_q.delete();
    idx_q.delete();
    flag_cyc = 0; first_lat = -1; done_lat = -1; seen = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; quantity = 4'($urandom);
    n = 1;
    while (!seen && n <= BUDGET) begin
      if (draw_stone_flag) flag_cyc++;
      if (pix.plot) begin
        got_q.push_back({pix.vga_x, pix.vga_y, pix.vga_colour});
        if (first_lat < 0) first_lat = n;
      end
      if (draw_stone_flag && !done && (idx_q.size() == 0 || idx_q[$] != draw_index))
        idx_q.push_back(draw_index);
      start = (n == mid_at);
      if (done) begin
        seen = 1'b1;
        done_lat = n;
        start = retrig;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check("pass_ends", int'(seen), 1);
    check("flag_drops", int'(draw_stone_flag), 0);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int c;
    c = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (draw_stone_flag || pix.plot || done) c++;
    end
    check(tag, c, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    col_tab = '{3'b111, 3'b110, 3'b011, 3'b101};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    tab[0] = '{qty:0, e0:rec(1, 1, 0, 1, 0),      e1:$urandom, e2:$urandom, exp_plots:0,   exp_cyc:1};
    tab[1] = '{qty:1, e0:rec(100, 50, 1, 1, 0),   e1:$urandom, e2:$urandom, exp_plots:256, exp_cyc:261};
    tab[2] = '{qty:3, e0:rec(10, 10, 0, 1, 0),    e1:rec(200, 100, 2, 0, 0),
               e2:rec(40, 200, 3, 1, 1),                                   exp_plots:512, exp_cyc:525};
    tab[3] = '{qty:1, e0:rec(310, 230, 2, 1, 0),  e1:$urandom, e2:$urandom, exp_plots:100, exp_cyc:261};
    tab[4] = '{qty:1, e0:rec(319, 239, 3, 1, 0),  e1:$urandom, e2:$urandom, exp_plots:1,   exp_cyc:261};
    tab[5] = '{qty:1, e0:rec(511, 255, 0, 1, 0),  e1:$urandom, e2:$urandom, exp_plots:0,   exp_cyc:261};
    tab[6] = '{qty:1, e0:rec(5, 5, 1, 0, 1),      e1:$urandom, e2:$urandom, exp_plots:0,   exp_cyc:5};
    tab[7] = '{qty:2, e0:rec(304, 0, 1, 1, 1),    e1:rec(0, 224, 0, 1, 0),
               e2:$urandom,                                                exp_plots:512, exp_cyc:521};

    // Reset values.
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_flag", int'(draw_stone_flag), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(pix.plot), 0);
    check("rst_index", int'(draw_index), 0);
    check("rst_x", int'(pix.vga_x), 0);
    check("rst_y", int'(pix.vga_y), 0);
    check("rst_colour", int'(pix.vga_colour), 0);
    resetn = 1'b1;

    // Empty table: straight to DONE.
    quantity = 4'd0;
    run_pass(0, 1'b0);
    check("q0_done_lat", done_lat, 1);
    check("q0_flag_cycles", flag_cyc, 1);
    check("q0_plots", got_q.size(), 0);

    // Single gold item: latency, first/last pixel, pass length.
    do_reset();
    mem[0] = rec(100, 50, 1, 1, 0);
    quantity = 4'd1;
    run_pass(0, 1'b0);
    check("t2_first_lat", first_lat, 4);
    check("t2_first_pix", got_q.size() > 0 ? int'(got_q[0]) : -1, int'({9'd100, 8'd50, 3'b110}));
    check("t2_last_pix", got_q.size() > 0 ? int'(got_q[$]) : -1, int'({9'd115, 8'd65, 3'b110}));
    check("t2_plots", got_q.size(), 256);
    check("t2_done_lat", done_lat, 261);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mem[0] = tab[i].e0;
      mem[1] = tab[i].e1;
      mem[2] = tab[i].e2;
      quantity = 4'(tab[i].qty);
      build_exp(tab[i].qty);
      run_pass(0, 1'b0);
      check($sformatf("v%0d_plots", i), got_q.size(), tab[i].exp_plots);
      check($sformatf("v%0d_cycles", i), done_lat, tab[i].exp_cyc);
      check($sformatf("v%0d_flag", i), flag_cyc, tab[i].exp_cyc);
      cmp_list($sformatf("v%0d", i));
      check_idx($sformatf("v%0d", i), tab[i].qty);
    end

    // start mid-pass and start coincident with done are both ignored.
    do_reset();
    mem[0] = rec(100, 50, 2, 1, 0);
    quantity = 4'd1;
    run_pass(50, 1'b1);
    check("retrig_done_lat", done_lat, 261);
    check("retrig_plots", got_q.size(), 256);
    idle_watch("retrig_idle", 20);

    // Reset in the middle of DRAW aborts at once.
    do_reset();
    mem[0] = rec(100, 50, 1, 1, 0);
    quantity = 4'd1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (20) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (60) @(negedge clock);
    check("mid_flag", int'(draw_stone_flag), 1);
    check("mid_plot", int'(pix.plot), 1);
    resetn = 1'b0;
    @(negedge clock);
    check("abort_plot", int'(pix.plot), 0);
    check("abort_flag", int'(draw_stone_flag), 0);
    check("abort_done", int'(done), 0);
    check("abort_index", int'(draw_index), 0);
    resetn = 1'b1;
    idle_watch("abort_idle", 300);

    // Random tables.
    for (int it = 0; it < 6; it++) begin
      int q;
      do_reset();
      for (int i = 0; i < 16; i++)
        mem[i] = rec($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom_range(0, 1));
      q = $urandom_range(0, 4);
      quantity = 4'(q);
      build_exp(q);
      run_pass(0, 1'b0);
      check($sformatf("r%0d_cycles", it), done_lat, exp_cyc);
      cmp_list($sformatf("r%0d", it));
      check_idx($sformatf("r%0d", it), q);
    end

`ifdef STONE_ERASE_EN
    // Moved item: old square repainted in background before the new one.
    do_reset();
    mem[0] = rec(100, 50, 1, 1, 0);
    quantity = 4'd1;
    run_pass(0, 1'b0);
    mem[0] = rec(120, 50, 1, 1, 0);
    quantity = 4'd1;
    run_pass(0, 1'b0);
    exp_q.delete();
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++)
        exp_q.push_back({9'(100 + dx), 8'(50 + dy), 3'b000});
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++)
        exp_q.push_back({9'(120 + dx), 8'(50 + dy), 3'b110});
    cmp_list("erase");
    check("erase_done_lat", done_lat, 517);
`endif

    m = miscompares;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, m);
    $finish;
  end
endmodule
